// File: rtl/pe_sequencer.sv
// rtl/pe_sequencer.sv - row-stationary PE load/compute/readout sequencer
//
// Purpose: owns every scratchpad address and enable of one processing element.
//   Loads S filter taps and W ifmap words, then issues S*E multiply-accumulate
//   address triples (E = W - S + 1), drains the mult/add pipeline, and streams
//   the E partial-sum addresses out under a valid/ready handshake.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start                 one-cycle pass request, honoured only in IDLE
//   i_cfg_s_m1, i_cfg_w_m1  filter taps S-1, ifmap length W-1
//   i_filt_valid  / o_filt_ready   filter load handshake
//   i_ifmap_valid / o_ifmap_ready  ifmap load handshake
//   o_load_filter, o_load_ifmap    scratchpad write strobes
//   o_ld_addr_filter, o_ld_addr_ifmap  scratchpad write addresses
//   o_sel_filter_addr, o_sel_ifmap_addr  scratchpad read addresses
//   o_psum_sel              psum address (accumulate or readout)
//   o_en, o_psum_clr        datapath enable, accumulator restart
//   o_out_valid / i_out_ready  psum readout handshake
//   o_done                  one-cycle pulse at pass end
//   o_err                   sticky until next start; S > W
module pe_sequencer #(
  parameter int FILT_AW    = 6,
  parameter int IFMAP_AW   = 4,
  parameter int PSUM_AW    = 4,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [FILT_AW-1:0]  i_cfg_s_m1,
  input  logic [IFMAP_AW-1:0] i_cfg_w_m1,
  input  logic                i_filt_valid,
  output logic                o_filt_ready,
  input  logic                i_ifmap_valid,
  output logic                o_ifmap_ready,
  output logic                o_load_filter,
  output logic                o_load_ifmap,
  output logic [FILT_AW-1:0]  o_ld_addr_filter,
  output logic [IFMAP_AW-1:0] o_ld_addr_ifmap,
  output logic [FILT_AW-1:0]  o_sel_filter_addr,
  output logic [IFMAP_AW-1:0] o_sel_ifmap_addr,
  output logic [PSUM_AW-1:0]  o_psum_sel,
  output logic                o_en,
  output logic                o_psum_clr,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic                o_done,
  output logic                o_err
);

  localparam int CW = (FILT_AW > IFMAP_AW) ? FILT_AW : IFMAP_AW;
  localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_F, S_LOAD_I, S_COMPUTE, S_DRAIN, S_READOUT, S_FIN
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [FILT_AW-1:0]  r_s_m1, w_s_m1_nxt;
  logic [IFMAP_AW-1:0] r_w_m1, w_w_m1_nxt;
  logic [IFMAP_AW-1:0] r_e_m1, w_e_m1_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [FILT_AW-1:0]  r_s, w_s_nxt;
  logic [IFMAP_AW-1:0] r_e, w_e_nxt;
  logic [PSUM_AW-1:0]  r_r, w_r_nxt;
  logic [DW-1:0]       r_dcnt, w_dcnt_nxt;
  logic                r_err, w_err_nxt;

  // Compute/readout outputs are registered from next-state values so they
  // line up with the state they belong to.
  logic [FILT_AW-1:0]  r_sel_f, w_sel_f_nxt;
  logic [IFMAP_AW-1:0] r_sel_i, w_sel_i_nxt;
  logic [PSUM_AW-1:0]  r_psum_sel, w_psum_sel_nxt;
  logic                r_en, w_en_nxt;
  logic                r_clr, w_clr_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic                r_done, w_done_nxt;

  logic w_in_lf, w_in_li;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_s_m1      <= '0;
      r_w_m1      <= '0;
      r_e_m1      <= '0;
      r_cnt       <= '0;
      r_s         <= '0;
      r_e         <= '0;
      r_r         <= '0;
      r_dcnt      <= '0;
      r_err       <= 1'b0;
      r_sel_f     <= '0;
      r_sel_i     <= '0;
      r_psum_sel  <= '0;
      r_en        <= 1'b0;
      r_clr       <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_s_m1      <= w_s_m1_nxt;
      r_w_m1      <= w_w_m1_nxt;
      r_e_m1      <= w_e_m1_nxt;
      r_cnt       <= w_cnt_nxt;
      r_s         <= w_s_nxt;
      r_e         <= w_e_nxt;
      r_r         <= w_r_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_err       <= w_err_nxt;
      r_sel_f     <= w_sel_f_nxt;
      r_sel_i     <= w_sel_i_nxt;
      r_psum_sel  <= w_psum_sel_nxt;
      r_en        <= w_en_nxt;
      r_clr       <= w_clr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_m1_nxt  = r_s_m1;
    w_w_m1_nxt  = r_w_m1;
    w_e_m1_nxt  = r_e_m1;
    w_cnt_nxt   = r_cnt;
    w_s_nxt     = r_s;
    w_e_nxt     = r_e;
    w_r_nxt     = r_r;
    w_dcnt_nxt  = r_dcnt;
    w_err_nxt   = r_err;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_s_m1_nxt = i_cfg_s_m1;
          w_w_m1_nxt = i_cfg_w_m1;
          // E-1 = (W-1) - (S-1); only meaningful when S <= W, which bounds it.
          w_e_m1_nxt = i_cfg_w_m1 - IFMAP_AW'(i_cfg_s_m1);
          w_cnt_nxt  = '0;
          if (32'(i_cfg_s_m1) > 32'(i_cfg_w_m1)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_FIN;
          end else begin
            w_err_nxt   = 1'b0;
            w_state_nxt = S_LOAD_F;
          end
        end
      end
      S_LOAD_F: begin
        if (i_filt_valid) begin
          if (r_cnt == CW'(r_s_m1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_LOAD_I;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_LOAD_I: begin
        if (i_ifmap_valid) begin
          if (r_cnt == CW'(r_w_m1)) begin
            w_cnt_nxt   = '0;
            w_s_nxt     = '0;
            w_e_nxt     = '0;
            w_state_nxt = S_COMPUTE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      S_COMPUTE: begin
        // Tap s is the inner loop, output e the outer one.
        if (r_s == r_s_m1) begin
          w_s_nxt = '0;
          if (r_e == r_e_m1) begin
            w_dcnt_nxt  = '0;
            w_state_nxt = S_DRAIN;
          end else begin
            w_e_nxt = r_e + IFMAP_AW'(1);
          end
        end else begin
          w_s_nxt = r_s + FILT_AW'(1);
        end
      end
      S_DRAIN: begin
        if (r_dcnt == DW'(PIPE_DEPTH - 1)) begin
          w_r_nxt     = '0;
          w_state_nxt = S_READOUT;
        end else begin
          w_dcnt_nxt = r_dcnt + DW'(1);
        end
      end
      S_READOUT: begin
        if (i_out_ready) begin
          if (r_r == PSUM_AW'(r_e_m1)) begin
            w_state_nxt = S_FIN;
          end else begin
            w_r_nxt = r_r + PSUM_AW'(1);
          end
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_en_nxt        = (w_state_nxt == S_COMPUTE) || (w_state_nxt == S_DRAIN);
    w_clr_nxt       = (w_state_nxt == S_COMPUTE) && (w_s_nxt == '0);
    w_out_valid_nxt = (w_state_nxt == S_READOUT);
    w_done_nxt      = (w_state_nxt == S_FIN);
    w_sel_f_nxt     = '0;
    w_sel_i_nxt     = '0;
    w_psum_sel_nxt  = '0;
    if (w_state_nxt == S_COMPUTE) begin
      w_sel_f_nxt    = w_s_nxt;
      // e + s never exceeds W-1, so dropping the carry bit is safe.
      w_sel_i_nxt    = IFMAP_AW'((IFMAP_AW+1)'(w_e_nxt) + (IFMAP_AW+1)'(w_s_nxt));
      w_psum_sel_nxt = PSUM_AW'(w_e_nxt);
    end else if (w_state_nxt == S_DRAIN) begin
      w_psum_sel_nxt = PSUM_AW'(r_e_m1);
    end else if (w_state_nxt == S_READOUT) begin
      w_psum_sel_nxt = w_r_nxt;
    end
  end

  // Load side is combinational so a transfer is written in the cycle it is offered.
  assign w_in_lf = (r_state == S_LOAD_F);
  assign w_in_li = (r_state == S_LOAD_I);

  assign o_filt_ready      = w_in_lf;
  assign o_ifmap_ready     = w_in_li;
  assign o_load_filter     = w_in_lf & i_filt_valid;
  assign o_load_ifmap      = w_in_li & i_ifmap_valid;
  assign o_ld_addr_filter  = w_in_lf ? FILT_AW'(r_cnt) : '0;
  assign o_ld_addr_ifmap   = w_in_li ? IFMAP_AW'(r_cnt) : '0;
  assign o_sel_filter_addr = r_sel_f;
  assign o_sel_ifmap_addr  = r_sel_i;
  assign o_psum_sel        = r_psum_sel;
  assign o_en              = r_en;
  assign o_psum_clr        = r_clr;
  assign o_out_valid       = r_out_valid;
  assign o_done            = r_done;
  assign o_err             = r_err;

endmodule

// File: tb/tb_pe_sequencer.sv
// tb/tb_pe_sequencer.sv - scoreboard bench for pe_sequencer
module tb_pe_sequencer;

  localparam int PIPE = 3;

  typedef struct {
    int f;
    int i;
    int p;
    bit clr;
  } comp_t;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_start;
  logic [5:0] i_cfg_s_m1;
  logic [3:0] i_cfg_w_m1;
  logic       i_filt_valid, i_ifmap_valid, i_out_ready;
  logic       o_filt_ready, o_ifmap_ready, o_load_filter, o_load_ifmap;
  logic [5:0] o_ld_addr_filter, o_sel_filter_addr;
  logic [3:0] o_ld_addr_ifmap, o_sel_ifmap_addr, o_psum_sel;
  logic       o_en, o_psum_clr, o_out_valid, o_done, o_err;
  logic [32:0] w_outs;

  int n_chk  = 0;
  int n_pass = 0;
  comp_t q_comp[$];
  int    q_rd[$];

  always #5 clk = ~clk;

  assign w_outs = {o_filt_ready, o_ifmap_ready, o_load_filter, o_load_ifmap,
                   o_ld_addr_filter, o_ld_addr_ifmap, o_sel_filter_addr,
                   o_sel_ifmap_addr, o_psum_sel, o_en, o_psum_clr,
                   o_out_valid, o_done, o_err};

  pe_sequencer #(.FILT_AW(6), .IFMAP_AW(4), .PSUM_AW(4), .PIPE_DEPTH(PIPE)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_cfg_s_m1(i_cfg_s_m1), .i_cfg_w_m1(i_cfg_w_m1),
    .i_filt_valid(i_filt_valid), .o_filt_ready(o_filt_ready),
    .i_ifmap_valid(i_ifmap_valid), .o_ifmap_ready(o_ifmap_ready),
    .o_load_filter(o_load_filter), .o_load_ifmap(o_load_ifmap),
    .o_ld_addr_filter(o_ld_addr_filter), .o_ld_addr_ifmap(o_ld_addr_ifmap),
    .o_sel_filter_addr(o_sel_filter_addr), .o_sel_ifmap_addr(o_sel_ifmap_addr),
    .o_psum_sel(o_psum_sel), .o_en(o_en), .o_psum_clr(o_psum_clr),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_done(o_done), .o_err(o_err)
  );

  // One full pass. Cycle 0 is the cycle start is presented; done is expected
  // on cycle 1+S+W+S*E+PIPE+E plus any backpressure cycles.
  task automatic run_pass(input int s, input int w, input bit fpat,
                          input int stall_n, input bit start_mid, input int rst_at);
    comp_t c;
    int e, exp_done, en_seen, f_ld, i_ld, stall_left;
    int last_f, last_i, first_fr, first_ir, first_en;
    bit fin;
    e = w - s + 1;
    exp_done = 1 + s + w + s * e + PIPE + e + (fpat ? s - 1 : 0) + stall_n;
    q_comp.delete();
    q_rd.delete();
    for (int ee = 0; ee < e; ee++) begin
      for (int ss = 0; ss < s; ss++) begin
        c.f = ss; c.i = ee + ss; c.p = ee; c.clr = (ss == 0);
        q_comp.push_back(c);
      end
      q_rd.push_back(ee);
    end
    en_seen = 0; f_ld = 0; i_ld = 0; stall_left = stall_n;
    last_f = -1; last_i = -1; first_fr = -1; first_ir = -1; first_en = -1;
    fin = 1'b0;

    @(negedge clk);
    i_start = 1'b1;
    i_cfg_s_m1 = 6'(s - 1);
    i_cfg_w_m1 = 4'(w - 1);
    i_filt_valid = 1'b0; i_ifmap_valid = 1'b0; i_out_ready = 1'b1;
    #1;
    n_chk++;
    if (o_filt_ready !== 1'b0 || o_en !== 1'b0 || o_done !== 1'b0)
      $display("FAIL start_cycle_idle: ready=%0b en=%0b done=%0b, required 0 0 0", o_filt_ready, o_en, o_done);
    else n_pass++;

    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge clk);
      i_start = start_mid && (en_seen == 2);
      if (i_start) begin
        i_cfg_s_m1 = 6'd0;
        i_cfg_w_m1 = 4'd15;
      end
      i_filt_valid  = fpat ? (cyc % 2 == 1) : 1'b1;
      i_ifmap_valid = 1'b1;
      if (o_out_valid && o_psum_sel == 4'd1 && stall_left > 0) begin
        i_out_ready = 1'b0;
        stall_left--;
      end else begin
        i_out_ready = 1'b1;
      end
      #1;
      if (cyc == 1) begin
        n_chk++;
        if (o_err !== 1'b0) $display("FAIL err_clear_on_start: err=%0b, required 0", o_err);
        else n_pass++;
      end
      if (o_filt_ready && first_fr < 0) first_fr = cyc;
      if (o_ifmap_ready && first_ir < 0) first_ir = cyc;
      if (o_load_filter) begin
        n_chk++;
        if (o_ld_addr_filter !== 6'(f_ld))
          $display("FAIL ld_addr_filter: got %0d, required %0d", o_ld_addr_filter, f_ld);
        else n_pass++;
        f_ld++; last_f = cyc;
      end
      if (o_load_ifmap) begin
        n_chk++;
        if (o_ld_addr_ifmap !== 4'(i_ld))
          $display("FAIL ld_addr_ifmap: got %0d, required %0d", o_ld_addr_ifmap, i_ld);
        else n_pass++;
        i_ld++; last_i = cyc;
      end
      if (o_en) begin
        if (first_en < 0) first_en = cyc;
        n_chk++;
        if (o_load_filter || o_load_ifmap || o_out_valid) begin
          $display("FAIL overlap: en with load_f=%0b load_i=%0b out_valid=%0b, required 0", o_load_filter, o_load_ifmap, o_out_valid);
        end else if (en_seen < s * e) begin
          if (q_comp.size() == 0) begin
            $display("FAIL compute_extra: unexpected compute cycle %0d", en_seen);
          end else begin
            c = q_comp.pop_front();
            if (o_sel_filter_addr !== 6'(c.f) || o_sel_ifmap_addr !== 4'(c.i) ||
                o_psum_sel !== 4'(c.p) || o_psum_clr !== c.clr)
              $display("FAIL compute_addr: got f=%0d i=%0d p=%0d clr=%0b, required f=%0d i=%0d p=%0d clr=%0b",
                       o_sel_filter_addr, o_sel_ifmap_addr, o_psum_sel, o_psum_clr, c.f, c.i, c.p, c.clr);
            else n_pass++;
          end
        end else begin
          if (o_psum_sel !== 4'(e - 1) || o_psum_clr !== 1'b0)
            $display("FAIL drain: got psum_sel=%0d clr=%0b, required %0d 0", o_psum_sel, o_psum_clr, e - 1);
          else n_pass++;
        end
        en_seen++;
      end
      if (o_out_valid) begin
        n_chk++;
        if (q_rd.size() == 0) begin
          $display("FAIL readout_extra: psum_sel=%0d with nothing expected", o_psum_sel);
        end else begin
          if (o_psum_sel !== 4'(q_rd[0]))
            $display("FAIL readout_addr: got %0d, required %0d", o_psum_sel, q_rd[0]);
          else n_pass++;
          if (i_out_ready) void'(q_rd.pop_front());
        end
      end
      if (o_done) begin
        fin = 1'b1;
        n_chk++;
        if (cyc !== exp_done) $display("FAIL done_cycle: got %0d, required %0d", cyc, exp_done);
        else n_pass++;
        n_chk++;
        if (f_ld !== s || i_ld !== w)
          $display("FAIL load_counts: got f=%0d i=%0d, required f=%0d i=%0d", f_ld, i_ld, s, w);
        else n_pass++;
        n_chk++;
        if (en_seen !== s * e + PIPE || q_comp.size() != 0 || q_rd.size() != 0)
          $display("FAIL en_cycles: got %0d left_c=%0d left_r=%0d, required %0d 0 0",
                   en_seen, q_comp.size(), q_rd.size(), s * e + PIPE);
        else n_pass++;
        n_chk++;
        if (first_fr !== 1 || first_ir !== last_f + 1 || first_en !== last_i + 1)
          $display("FAIL phase_latency: got fr=%0d ir=%0d en=%0d, required 1 %0d %0d",
                   first_fr, first_ir, first_en, last_f + 1, last_i + 1);
        else n_pass++;
        n_chk++;
        if (o_err !== 1'b0) $display("FAIL err_at_done: got %0b, required 0", o_err);
        else n_pass++;
      end
      if (rst_at >= 0 && en_seen == rst_at) begin
        i_rst_n = 1'b0;
        #1;
        n_chk++;
        if (w_outs !== '0) $display("FAIL async_reset_outputs: got %h, required 0", w_outs);
        else n_pass++;
        @(negedge clk);
        i_rst_n = 1'b1;
        i_start = 1'b0;
        return;
      end
    end
    if (!fin) begin
      n_chk++;
      $display("FAIL done_timeout: no done within 400 cycles (S=%0d W=%0d)", s, w);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (w_outs !== '0) $display("FAIL reset_outputs: got %h, required 0", w_outs);
    else n_pass++;
    i_rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_chk++;
    if (w_outs !== '0) $display("FAIL idle_outputs: got %h, required 0", w_outs);
    else n_pass++;
  endtask

  task automatic test_basic();
    run_pass(3, 5, 1'b0, 0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_pass(3, 3, 1'b0, 0, 1'b0, -1);
    run_pass(1, 4, 1'b0, 0, 1'b0, -1);
    run_pass(2, 16, 1'b0, 0, 1'b0, -1);
  endtask

  task automatic test_load_backpressure();
    run_pass(4, 6, 1'b1, 0, 1'b0, -1);
  endtask

  task automatic test_readout_stall();
    run_pass(3, 5, 1'b0, 5, 1'b0, -1);
  endtask

  task automatic test_error();
    int loads;
    loads = 0;
    @(negedge clk);
    i_start = 1'b1; i_cfg_s_m1 = 6'd5; i_cfg_w_m1 = 4'd3;
    i_filt_valid = 1'b1; i_ifmap_valid = 1'b1; i_out_ready = 1'b1;
    #1;
    if (o_load_filter || o_load_ifmap) loads++;
    @(negedge clk);
    i_start = 1'b0;
    #1;
    if (o_load_filter || o_load_ifmap) loads++;
    n_chk++;
    if (o_done !== 1'b1 || o_err !== 1'b1)
      $display("FAIL error_fin: got done=%0b err=%0b, required 1 1", o_done, o_err);
    else n_pass++;
    n_chk++;
    if (o_filt_ready || o_ifmap_ready || o_en || o_out_valid)
      $display("FAIL error_quiet: got frdy=%0b irdy=%0b en=%0b ov=%0b, required 0", o_filt_ready, o_ifmap_ready, o_en, o_out_valid);
    else n_pass++;
    @(negedge clk);
    #1;
    if (o_load_filter || o_load_ifmap) loads++;
    n_chk++;
    if (o_done !== 1'b0 || o_err !== 1'b1 || loads !== 0)
      $display("FAIL error_sticky: got done=%0b err=%0b loads=%0d, required 0 1 0", o_done, o_err, loads);
    else n_pass++;
    run_pass(2, 4, 1'b0, 0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_compute();
    run_pass(3, 5, 1'b0, 0, 1'b0, 4);
    run_pass(1, 1, 1'b0, 0, 1'b0, -1);
  endtask

  task automatic test_start_ignored();
    run_pass(3, 5, 1'b0, 0, 1'b1, -1);
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_cfg_s_m1 = '0; i_cfg_w_m1 = '0;
    i_filt_valid = 1'b0; i_ifmap_valid = 1'b0; i_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_load_backpressure();
    test_readout_stall();
    test_error();
    test_reset_mid_compute();
    test_start_ignored();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
